// File: rtl/rect_scan_counter.sv
// Raster scanner for a runtime-sized rectangle: walks x fastest, then y,
// qualifying each point with write_en and pulsing done when finished.
//
// Ports:
//   clk, resetn       : clock, async active-low reset
//   start             : begin a scan (sampled only while idle)
//   width, height     : rectangle size, latched on an accepted start
//   hold              : stall, freezes offsets and masks write_en
//   x_off, y_off      : current point offsets
//   write_en          : current point is valid this cycle
//   busy, done        : scanning / one-cycle completion pulse
module rect_scan_counter #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [XW-1:0] width,
  input  logic [YW-1:0] height,
  input  logic          hold,
  output logic [XW-1:0] x_off,
  output logic [YW-1:0] y_off,
  output logic          write_en,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [XW-1:0] w_q, w_d;
  logic [YW-1:0] h_q, h_d;

  // Latched sizes are non-zero while running, so these never wrap.
  logic [XW-1:0] x_last;
  logic [YW-1:0] y_last;

  assign x_last = w_q - XW'(1);
  assign y_last = h_q - YW'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (width != '0 && height != '0) begin
            w_d     = width;
            h_d     = height;
            x_d     = '0;
            y_d     = '0;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (!hold) begin
          if (x_q < x_last) begin
            x_d = x_q + XW'(1);
          end else if (y_q < y_last) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d     = '0;
            y_d     = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign x_off    = x_q;
  assign y_off    = y_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign write_en = (state_q == RUN) & ~hold;

endmodule

// File: tb/tb_rect_scan_counter.sv
// Randomized bench for rect_scan_counter: a raster-order point model
// predicts offsets, write_en, busy and done every cycle.
module tb_rect_scan_counter;

  localparam int XW = 3;
  localparam int YW = 3;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [XW-1:0] width;
  logic [YW-1:0] height;
  logic          hold;
  logic [XW-1:0] x_off;
  logic [YW-1:0] y_off;
  logic          write_en;
  logic          busy;
  logic          done;

  int n_chk;
  int n_err;

  rect_scan_counter #(
    .XW(XW),
    .YW(YW)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .width   (width),
    .height  (height),
    .hold    (hold),
    .x_off   (x_off),
    .y_off   (y_off),
    .write_en(write_en),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Issues a start, then walks the scan cycle by cycle. The model is
  // the list of points in raster order: point idx is
  // (idx % w, idx / w), consumed on every non-held cycle.
  task automatic run_scan(input int w, input int h,
                          input int pct,
                          input logic [63:0] mask,
                          input bit poke);
    int idx;
    int cyc;
    int n;
    int bound;
    idx   = 0;
    cyc   = 0;
    n     = w * h;
    bound = 4 * n + 20;
    @(negedge clk);
    start  = 1'b1;
    width  = XW'(w);
    height = YW'(h);
    hold   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (idx < n && cyc < bound) begin
      hold = mask[cyc % 64] |
             ($urandom_range(99) < 32'(pct));
      start  = ($urandom_range(3) == 0);
      width  = XW'($urandom);
      height = YW'($urandom);
      #1;
      check("busy", int'(busy), 1);
      check("done_run", int'(done), 0);
      check("we", int'(write_en), int'(!hold));
      check("x", int'(x_off), idx % w);
      check("y", int'(y_off), idx / w);
      if (!hold) idx++;
      cyc++;
      @(negedge clk);
    end
    check("timeout", int'(cyc < bound), 1);
    check("nwrites", idx, n);
    start = 1'b0;
    hold  = 1'($urandom);
    #1;
    check("done", int'(done), 1);
    check("busy_done", int'(busy), 0);
    check("we_done", int'(write_en), 0);
    check("x_done", int'(x_off), 0);
    check("y_done", int'(y_off), 0);
    if (poke) begin
      start  = 1'b1;
      width  = XW'($urandom_range(1, 7));
      height = YW'($urandom_range(1, 7));
      @(negedge clk);
      start = 1'b0;
      #1;
      check("poke_busy", int'(busy), 0);
      check("poke_done", int'(done), 0);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    resetn = 1'b0;
    start  = 1'b0;
    width  = '0;
    height = '0;
    hold   = 1'b0;
    #12;
    check("rst_x", int'(x_off), 0);
    check("rst_y", int'(y_off), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_we", int'(write_en), 0);
    @(negedge clk);
    resetn = 1'b1;

    run_scan(4, 3, 0, 64'd0, 1'b0);
    run_scan(3, 2, 0, 64'h12, 1'b1);
    run_scan(0, 5, 0, 64'd0, 1'b1);
    run_scan(5, 0, 0, 64'd0, 1'b0);
    run_scan(2, 2, 0, 64'd0, 1'b0);
    run_scan(1, 1, 0, 64'd0, 1'b0);
    run_scan(7, 7, 0, 64'd0, 1'b1);
    run_scan(7, 3, 25, 64'd0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_scan($urandom_range(0, 7), $urandom_range(0, 7),
               30, 64'd0, 1'($urandom));
    end

    // Asynchronous reset in the middle of a 4x4 scan at (2,1).
    @(negedge clk);
    start  = 1'b1;
    width  = XW'(4);
    height = YW'(4);
    hold   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("pre_rst_x", int'(x_off), 2);
    check("pre_rst_y", int'(y_off), 1);
    check("pre_rst_we", int'(write_en), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_x", int'(x_off), 0);
    check("arst_y", int'(y_off), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_we", int'(write_en), 0);
    check("arst_done", int'(done), 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post_rst_done", int'(done), 0);
    check("post_rst_busy", int'(busy), 0);
    run_scan(1, 2, 0, 64'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
